// File: rtl/trig_record_fifo.sv
// Trigger record FIFO: stores {fired bits, timestamp} records and returns the oldest one
// as two 32-bit words on request, counting records dropped while full.
module trig_record_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TS_W  = 56
) (
    input  logic              clk_adc,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_valid,
    input  logic [7:0]        wr_bits,
    input  logic [TS_W-1:0]   wr_time,
    input  logic              rd_req,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic [15:0]       overflow_cnt
);

    localparam int REC_W = 8 + TS_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_W0    = 3'd2,
        S_W1    = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [REC_W-1:0]   rec_q, rec_d;
    logic [63:0]        rec_ext_s;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [15:0]        ovf_q, ovf_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_last_q, rd_last_d;
    logic               wr_fire_s;
    logic               wr_acc_s;
    logic               ovf_inc_s;
    logic               pop_s;

    assign rec_ext_s = 64'(rec_q);

    // Write qualification: zero bitstrings are not records; full is the registered value.
    always_comb begin
        wr_fire_s = wr_valid && (wr_bits != 8'h00);
        wr_acc_s  = wr_fire_s && !full_q && !clear;
        ovf_inc_s = wr_fire_s && full_q && !clear;
    end

    // Readout FSM next state and pop strobe.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d = empty_q ? S_EMPTY : S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_W0;
            S_W0:    state_d = S_W1;
            S_W1: begin
                state_d = S_IDLE;
                pop_s   = 1'b1;
            end
            S_EMPTY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            pop_s   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Output words registered from the state being processed; clear kills an in-flight word.
    always_comb begin
        rd_data_d  = 32'h0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rec_d      = rec_q;
        case (state_q)
            S_FETCH: rec_d = mem_q[rd_ptr_q];
            S_W0: begin
                rd_valid_d = 1'b1;
                rd_data_d  = rec_ext_s[31:0];
            end
            S_W1: begin
                rd_valid_d = 1'b1;
                rd_last_d  = 1'b1;
                rd_data_d  = rec_ext_s[63:32];
            end
            S_EMPTY: begin
                rd_valid_d = 1'b1;
                rd_last_d  = 1'b1;
            end
            default: rec_d = rec_q;
        endcase
        if (clear) begin
            rd_data_d  = 32'h0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            rd_valid_d = rd_valid_d;
        end
    end

    // Pointer, occupancy and overflow bookkeeping; full/empty derive from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
            ovf_d    = 16'h0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            if (ovf_inc_s && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 16'h1;
            end else begin
                ovf_d = ovf_q;
            end
        end
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == {(AW+1){1'b0}});
    end

    // Record storage; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge clk_adc) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= {wr_bits, wr_time};
        end
    end

    // State and control registers.
    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rec_q      <= {REC_W{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 16'h0;
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_last_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trig_record_fifo.sv
// Scoreboard bench for trig_record_fifo: a queue-based model predicts readout words and
// occupancy; a negedge monitor compares everything the DUT presents.
module tb_trig_record_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TS_W  = 56;

    logic            clk_adc = 1'b0;
    logic            reset;
    logic            clear;
    logic            wr_valid;
    logic [7:0]      wr_bits;
    logic [TS_W-1:0] wr_time;
    logic            rd_req;
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic            rd_last;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic [15:0]     overflow_cnt;

    trig_record_fifo #(.DEPTH(DEPTH), .AW(AW), .TS_W(TS_W)) dut (
        .clk_adc(clk_adc), .reset(reset), .clear(clear),
        .wr_valid(wr_valid), .wr_bits(wr_bits), .wr_time(wr_time),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .count(count), .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
    );

    always #5 clk_adc = ~clk_adc;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] mq[$];
    word_t       exq[$];
    word_t       w;
    int          busy    = 0;
    bit          busy_rd = 1'b0;
    int          m_ovf   = 0;
    bit          mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour for one clock edge: response timing in cycles, storage as a queue.
    function automatic void model_step(input bit wv, input logic [7:0] b,
                                       input logic [TS_W-1:0] t, input bit rr, input bit clr);
        bit full_b, empty_b, pop;
        logic [63:0] rec;
        if (clr) begin
            mq.delete();
            exq.delete();
            busy  = 0;
            m_ovf = 0;
            return;
        end
        full_b  = (mq.size() == DEPTH);
        empty_b = (mq.size() == 0);
        pop     = 1'b0;
        if (busy > 0) begin
            busy--;
            if (busy == 0 && busy_rd) pop = 1'b1;
        end else if (rr) begin
            if (empty_b) begin
                exq.push_back('{32'h0, 1'b1});
                busy    = 1;
                busy_rd = 1'b0;
            end else begin
                rec = mq[0];
                exq.push_back('{rec[31:0], 1'b0});
                exq.push_back('{rec[63:32], 1'b1});
                busy    = 3;
                busy_rd = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (wv && b != 8'h00) begin
            if (full_b) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                mq.push_back({b, t});
            end
        end
    endfunction

    task automatic step(input bit wv, input logic [7:0] b, input logic [TS_W-1:0] t,
                        input bit rr, input bit clr);
        wr_valid = wv;
        wr_bits  = b;
        wr_time  = t;
        rd_req   = rr;
        clear    = clr;
        @(posedge clk_adc);
        model_step(wv, b, t, rr, clr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 56'h0, 1'b0, 1'b0);
    endtask

    // Monitor: every presented word must match the scoreboard head; occupancy tracks the model.
    always @(negedge clk_adc) begin
        if (mon_en) begin
            if (rd_valid) begin
                if (exq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got data=%h last=%b, want no word (t=%0t)",
                             rd_data, rd_last, $time);
                end else begin
                    w = exq.pop_front();
                    check("rd_data", 64'(rd_data), 64'(w.d));
                    check("rd_last", 64'(rd_last), 64'(w.l));
                end
            end else begin
                check("idle_data", 64'(rd_data), 64'h0);
                check("idle_last", 64'(rd_last), 64'h0);
            end
            check("count", 64'(count), 64'(mq.size()));
            check("full", 64'(full), 64'(mq.size() == DEPTH));
            check("empty", 64'(empty), 64'(mq.size() == 0));
            check("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
        end
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_bits  = 8'h00;
        wr_time  = 56'h0;
        rd_req   = 1'b0;
        repeat (2) @(posedge clk_adc);
        #2;
        check("rst_data", 64'(rd_data), 64'h0);
        check("rst_valid", 64'(rd_valid), 64'h0);
        check("rst_last", 64'(rd_last), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_empty", 64'(empty), 64'h1);
        check("rst_full", 64'(full), 64'h0);
        check("rst_ovf", 64'(overflow_cnt), 64'h0);
        @(posedge clk_adc);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single record readout with exact word values.
        step(1'b1, 8'h05, 56'h00_1234_5678_9ABC, 1'b0, 1'b0);
        check("t1_count1", 64'(count), 64'h1);
        step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
        idle(2);
        check("t1_w0_valid", 64'(rd_valid), 64'h1);
        check("t1_w0_data", 64'(rd_data), 64'h5678_9ABC);
        check("t1_w0_last", 64'(rd_last), 64'h0);
        idle(1);
        check("t1_w1_data", 64'(rd_data), 64'h0500_1234);
        check("t1_w1_last", 64'(rd_last), 64'h1);
        check("t1_count0", 64'(count), 64'h0);
        check("t1_empty", 64'(empty), 64'h1);
        idle(2);

        // Read while empty gives a one-cycle marker.
        step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
        check("t2_not_yet", 64'(rd_valid), 64'h0);
        idle(1);
        check("t2_valid", 64'(rd_valid), 64'h1);
        check("t2_last", 64'(rd_last), 64'h1);
        check("t2_data", 64'(rd_data), 64'h0);
        check("t2_count", 64'(count), 64'h0);
        idle(2);

        // Fill past capacity, then a write racing the W1 pop.
        step(1'b0, 8'h00, 56'h0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i + 1), 56'(i), 1'b0, 1'b0);
        check("t3_full", 64'(full), 64'h1);
        check("t3_count", 64'(count), 64'd16);
        check("t3_ovf", 64'(overflow_cnt), 64'd2);
        step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 8'h77, 56'h99, 1'b0, 1'b0);
        check("t4_count", 64'(count), 64'd15);
        check("t4_ovf", 64'(overflow_cnt), 64'd3);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
            idle(3);
        end
        check("t3_drained", 64'(count), 64'h0);

        // Zero bitstring ignored; write and pop together keep the count.
        step(1'b0, 8'h00, 56'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 56'h1000 + 56'(i), 1'b0, 1'b0);
        step(1'b1, 8'h00, 56'h123, 1'b0, 1'b0);
        check("t5_count_zero_bits", 64'(count), 64'd3);
        check("t5_ovf_zero_bits", 64'(overflow_cnt), 64'h0);
        step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 8'h3C, 56'hABCDEF, 1'b0, 1'b0);
        check("t5_count_wr_pop", 64'(count), 64'd3);
        idle(2);

        // Randomized traffic alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            bit wv, rr, clr;
            logic [7:0] b;
            logic [TS_W-1:0] t;
            if ((i / 500) % 2 == 0) begin
                wv = ($urandom_range(0, 9) < 7);
                rr = ($urandom_range(0, 9) < 1);
            end else begin
                wv = ($urandom_range(0, 19) < 3);
                rr = ($urandom_range(0, 1) == 0);
            end
            b   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom());
            t   = 56'({$urandom(), $urandom()});
            clr = ($urandom_range(0, 299) == 0);
            step(wv, b, t, rr, clr);
        end
        idle(6);

        // Clear during a response aborts it.
        step(1'b0, 8'h00, 56'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 8'h81, 56'(i * 3), 1'b0, 1'b0);
        check("t6_ovf_pre", 64'(overflow_cnt), 64'h1);
        step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
        idle(2);
        check("t6_w0_valid", 64'(rd_valid), 64'h1);
        check("t6_w0_last", 64'(rd_last), 64'h0);
        step(1'b0, 8'h00, 56'h0, 1'b0, 1'b1);
        check("t6_clr_valid", 64'(rd_valid), 64'h0);
        check("t6_clr_count", 64'(count), 64'h0);
        check("t6_clr_ovf", 64'(overflow_cnt), 64'h0);
        idle(3);

        // Asynchronous reset mid-response.
        step(1'b1, 8'h11, 56'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 56'h44, 1'b0, 1'b0);
        step(1'b0, 8'h00, 56'h0, 1'b1, 1'b0);
        idle(2);
        check("rst_mid_w0", 64'(rd_valid), 64'h1);
        reset = 1'b1;
        #2;
        check("rst_mid_valid", 64'(rd_valid), 64'h0);
        check("rst_mid_count", 64'(count), 64'h0);
        check("rst_mid_empty", 64'(empty), 64'h1);
        model_step(1'b0, 8'h00, 56'h0, 1'b0, 1'b1);
        @(posedge clk_adc);
        #1;
        reset = 1'b0;
        idle(3);

        // Overflow counter saturation.
        step(1'b0, 8'h00, 56'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'hA5, 56'(i), 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) step(1'b1, 8'hA5, 56'h5, 1'b0, 1'b0);
        check("sat_reach", 64'(overflow_cnt), 64'hFFFF);
        step(1'b1, 8'h5A, 56'h6, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 56'h7, 1'b0, 1'b0);
        check("sat_hold", 64'(overflow_cnt), 64'hFFFF);
        idle(6);

        check("drain", 64'(exq.size()), 64'h0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
